// File: rtl/sample_packer_pkg.sv
// Shared sample-path constants and the lane-count width helper, also used by the window-function stage.
package sample_pkg;

  localparam int SAMPLE_W_DEF  = 8;
  localparam int N_SAMPLES_DEF = 8;
  localparam int CLK_DIV_DEF   = 5000;
  localparam int SEQ_W_DEF     = 8;

  // Width needed to hold a lane count of 0..n inclusive.
  function automatic int COUNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Packed-word output handshake from the sample packer to the window-function stage.
interface sample_packer_if
  import sample_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SEQ_W     = SEQ_W_DEF
);

  logic [SAMPLE_W*N_SAMPLES-1:0]    out_data;
  logic [COUNT_W(N_SAMPLES)-1:0]    out_count;
  logic [SEQ_W-1:0]                 out_seq;
  logic                             out_valid;
  logic                             out_ready;

  modport master (output out_data, out_count, out_seq, out_valid, input out_ready);
  modport slave  (input out_data, out_count, out_seq, out_valid, output out_ready);

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate clock enable: one-cycle strobe every CLK_DIV fastclk cycles while en is high.
// Dropping en parks the divider at 0, so the first tick after re-enable is a full period later.
module sample_tick_gen
  import sample_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic fastclk,
  input  logic rst_n,
  input  logic en,
  output logic sample_tick
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;

  assign sample_tick = en && (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || sample_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/sample_packer.sv
// Packs ticked samples LSB-first into N_SAMPLES-lane words; a word leaves one cycle after it completes.
// Single output slot: a word completing while the slot is stalled is dropped and flagged in overflow.
module sample_packer
  import sample_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int SEQ_W     = SEQ_W_DEF
) (
  input  logic                fastclk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                flush,
  input  logic                clr_ovf,
  output logic                sample_tick,
  output logic                overflow,
  sample_packer_if.master     bus
);

  localparam int CW     = COUNT_W(N_SAMPLES);
  localparam int WORD_W = SAMPLE_W * N_SAMPLES;

  typedef logic [CW-1:0] cnt_t;

  logic [WORD_W-1:0] pack_q, word_nxt, data_q;
  cnt_t              fill_q, fill_nxt, count_q;
  logic [SEQ_W-1:0]  seq_q, oseq_q;
  logic              valid_q, ovf_q;
  logic              word_done, slot_free;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .fastclk     (fastclk),
    .rst_n       (rst_n),
    .en          (en),
    .sample_tick (sample_tick)
  );

  // Capture happens before completion so a tick+flush cycle emits the new sample too.
  always_comb begin
    word_nxt = pack_q;
    fill_nxt = fill_q;
    if (sample_tick) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        if (cnt_t'(k) == fill_q) word_nxt[k*SAMPLE_W +: SAMPLE_W] = sample_in;
      end
      fill_nxt = fill_q + cnt_t'(1);
    end
    word_done = (fill_nxt == cnt_t'(N_SAMPLES)) || (flush && (fill_nxt != '0));
    slot_free = !valid_q || bus.out_ready;
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      oseq_q  <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (word_done) begin
        pack_q <= '0;
        fill_q <= '0;
        if (slot_free) begin
          data_q  <= word_nxt;
          count_q <= fill_nxt;
          oseq_q  <= seq_q;
          seq_q   <= seq_q + SEQ_W'(1);
        end
      end else begin
        pack_q <= word_nxt;
        fill_q <= fill_nxt;
      end
      valid_q <= (word_done && slot_free) || (valid_q && !bus.out_ready);
      // A drop in the same cycle as clr_ovf keeps the flag set.
      ovf_q   <= (word_done && !slot_free) || (ovf_q && !clr_ovf);
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
  assign bus.out_seq   = oseq_q;
  assign bus.out_valid = valid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_sample_packer.sv
// Scenario tasks with inline checks plus a cycle-level reference model feeding a word scoreboard.
module tb_sample_packer;
  import sample_pkg::*;

  localparam int SW = 8;
  localparam int NS = 4;
  localparam int CD = 4;
  localparam int QW = 4;
  localparam int CW = COUNT_W(NS);

  typedef logic [SW*NS-1:0] word_t;
  typedef struct packed {
    word_t          data;
    logic [CW-1:0]  cnt;
    logic [QW-1:0]  seq;
  } exp_t;

  logic          fastclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_tick;
  logic          overflow;
  logic          rand_rdy = 1'b0;

  sample_packer_if #(.SAMPLE_W(SW), .N_SAMPLES(NS), .SEQ_W(QW)) bus ();

  sample_packer #(.SAMPLE_W(SW), .N_SAMPLES(NS), .CLK_DIV(CD), .SEQ_W(QW)) dut (
    .fastclk     (fastclk),
    .rst_n       (rst_n),
    .en          (en),
    .sample_in   (sample_in),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .sample_tick (sample_tick),
    .overflow    (overflow),
    .bus         (bus)
  );

  always #5 fastclk = ~fastclk;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  // Reference model state
  int         mdiv, mfill;
  word_t      mpack;
  logic       mvalid, movf;
  logic [QW-1:0] mseq;

  always @(posedge fastclk or negedge rst_n) begin : model
    int    nd, nf;
    word_t np;
    logic  tk, done, v, ov;
    exp_t  e;
    if (!rst_n) begin
      mdiv   <= 0;
      mfill  <= 0;
      mpack  <= '0;
      mvalid <= 1'b0;
      movf   <= 1'b0;
      mseq   <= '0;
      q.delete();
    end else begin
      tk = en && (mdiv == CD - 1);
      nd = (!en || tk) ? 0 : mdiv + 1;
      nf = mfill;
      np = mpack;
      if (tk) begin
        np = np | (word_t'(sample_in) << (SW * nf));
        nf = nf + 1;
      end
      done = (nf == NS) || (flush && nf > 0);
      v = mvalid;
      if (mvalid && bus.out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        v = 1'b0;
      end
      ov = clr_ovf ? 1'b0 : movf;
      if (done) begin
        if (!v) begin
          e.data = np;
          e.cnt  = CW'(nf);
          e.seq  = mseq;
          q.push_back(e);
          mseq <= mseq + 1'b1;
          v = 1'b1;
        end else begin
          ov = 1'b1;
        end
        nf = 0;
        np = '0;
      end
      mdiv   <= nd;
      mfill  <= nf;
      mpack  <= np;
      mvalid <= v;
      movf   <= ov;
    end
  end

  always @(negedge fastclk) begin
    if (rst_n) begin
      total++;
      if (sample_tick !== (en && mdiv == CD - 1)) begin
        bad++;
        $display("FAIL mon_tick t=%0t got=%b want=%b", $time, sample_tick, (en && mdiv == CD - 1));
      end
      total++;
      if (bus.out_valid !== mvalid) begin
        bad++;
        $display("FAIL mon_valid t=%0t got=%b want=%b", $time, bus.out_valid, mvalid);
      end
      total++;
      if (overflow !== movf) begin
        bad++;
        $display("FAIL mon_ovf t=%0t got=%b want=%b", $time, overflow, movf);
      end
      if (bus.out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL mon_word t=%0t unexpected word data=%h", $time, bus.out_data);
        end else if (bus.out_data !== q[0].data || bus.out_count !== q[0].cnt ||
                     bus.out_seq !== q[0].seq) begin
          bad++;
          $display("FAIL mon_word t=%0t got=%h/%0d/%0d want=%h/%0d/%0d", $time, bus.out_data,
                   bus.out_count, bus.out_seq, q[0].data, q[0].cnt, q[0].seq);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge fastclk);
      #3;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic put_sample(input logic [SW-1:0] v);
    int n = 0;
    while (mdiv != CD - 1 && n < 40) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL put_sample no tick within 40 cycles");
    end
    sample_in = v;
    cyc(1);
  endtask

  task automatic do_reset;
    en = 1'b0;
    flush = 1'b0;
    clr_ovf = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_count !== '0 ||
        bus.out_seq !== '0 || overflow !== 1'b0 || sample_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d s=%0d o=%b t=%b want all 0",
               bus.out_valid, bus.out_data, bus.out_count, bus.out_seq, overflow, sample_tick);
    end
    do_reset();
  endtask

  task automatic test_basic;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    put_sample(8'h11);
    put_sample(8'h22);
    put_sample(8'h33);
    put_sample(8'h44);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211 || bus.out_count !== 3'd4 ||
        bus.out_seq !== 4'd0) begin
      bad++;
      $display("FAIL basic_word got v=%b %h/%0d/%0d want 1 44332211/4/0", bus.out_valid,
               bus.out_data, bus.out_count, bus.out_seq);
    end
    cyc(1);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_valid_pulse got=%b want=0", bus.out_valid);
    end
    n = 0;
    while (!sample_tick && n < 20) begin
      cyc(1);
      n++;
    end
    cyc(1);
    n = 1;
    while (!sample_tick && n < 20) begin
      cyc(1);
      n++;
    end
    total++;
    if (n != CD) begin
      bad++;
      $display("FAIL basic_tick_period got=%0d want=%0d", n, CD);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    bus.out_ready = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 8; i++) put_sample(SW'(i));
    total++;
    if (overflow !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 ||
        bus.out_seq !== 4'd0) begin
      bad++;
      $display("FAIL ovf_hold got o=%b v=%b %h seq=%0d want 1 1 04030201 0", overflow,
               bus.out_valid, bus.out_data, bus.out_seq);
    end
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=0", overflow);
    end
    bus.out_ready = 1'b1;
    cyc(1);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_accept got valid=%b want=0", bus.out_valid);
    end
    for (int i = 9; i <= 12; i++) put_sample(SW'(i));
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0C0B0A09 || bus.out_seq !== 4'd1) begin
      bad++;
      $display("FAIL ovf_next_seq got v=%b %h seq=%0d want 1 0c0b0a09 1", bus.out_valid,
               bus.out_data, bus.out_seq);
    end
  endtask

  task automatic test_flush;
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    put_sample(8'hAA);
    put_sample(8'hBB);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000BBAA || bus.out_count !== 3'd2) begin
      bad++;
      $display("FAIL flush_partial got v=%b %h/%0d want 1 0000bbaa/2", bus.out_valid,
               bus.out_data, bus.out_count);
    end
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty got valid=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_flush_tick;
    int n = 0;
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    put_sample(8'h01);
    put_sample(8'h02);
    while (mdiv != CD - 1 && n < 40) begin
      cyc(1);
      n++;
    end
    sample_in = 8'h03;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00030201 || bus.out_count !== 3'd3) begin
      bad++;
      $display("FAIL flush_tick got v=%b %h/%0d want 1 00030201/3", bus.out_valid,
               bus.out_data, bus.out_count);
    end
    for (int i = 4; i <= 7; i++) put_sample(SW'(i));
    total++;
    if (bus.out_data !== 32'h07060504 || bus.out_count !== 3'd4 || bus.out_seq !== 4'd1) begin
      bad++;
      $display("FAIL flush_tick_next got %h/%0d/%0d want 07060504/4/1", bus.out_data,
               bus.out_count, bus.out_seq);
    end
  endtask

  task automatic test_enable_reset;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    put_sample(8'h01);
    put_sample(8'h02);
    en = 1'b0;
    n = 0;
    repeat (20) begin
      cyc(1);
      if (sample_tick) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL en_low_ticks got=%0d want=0", n);
    end
    en = 1'b1;
    n = 0;
    while (!sample_tick && n < 20) begin
      cyc(1);
      n++;
    end
    total++;
    if (n != CD - 1) begin
      bad++;
      $display("FAIL en_restart_delay got=%0d want=%0d", n, CD - 1);
    end
    put_sample(8'h03);
    put_sample(8'h04);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201) begin
      bad++;
      $display("FAIL en_resume_word got v=%b %h want 1 04030201", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b0;
    for (int i = 5; i <= 9; i++) put_sample(SW'(i));
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_count !== '0 ||
        bus.out_seq !== '0 || overflow !== 1'b0 || sample_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b %h/%0d/%0d o=%b t=%b want all 0", bus.out_valid,
               bus.out_data, bus.out_count, bus.out_seq, overflow, sample_tick);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    for (int w = 0; w < 18; w++) begin
      for (int j = 0; j < NS; j++) put_sample(SW'($urandom));
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== QW'(w)) begin
        bad++;
        $display("FAIL b2b_seq word=%0d got v=%b seq=%0d want 1 %0d", w, bus.out_valid,
                 bus.out_seq, w % 16);
      end
    end
    rand_rdy = 1'b1;
    for (int w = 0; w < 12; w++) begin
      put_sample(SW'($urandom));
      put_sample(SW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
      end else begin
        put_sample(SW'($urandom));
        put_sample(SW'($urandom));
      end
    end
    rand_rdy = 1'b0;
    en = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);
    total++;
    if (bus.out_valid !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("FAIL drain got valid=%b pending=%0d want 0 0", bus.out_valid, q.size());
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_flush_tick();
    test_enable_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded time budget");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
